// File: rtl/mem_bist_seq.sv
// mem_bist_seq -- march-style memory self-test sequencer.
//
// Writes an incrementing pattern (seed + address) to every word of a DEPTH-word
// memory. It then reads every word back, holding each address for RD_WAIT+1
// cycles. Read data is compared against the pattern, and the sequencer counts
// mismatches and records the first failing address.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      asynchronous, active-high reset
//   start      run request, honoured only when idle or done
//   seed       pattern seed, captured when start is accepted
//   addr       memory address
//   data_in    memory write data
//   write      memory write strobe
//   read       memory read strobe
//   data_out   memory read data
//   busy       run in progress
//   done       run complete (level, held until the next start)
//   pass       no mismatches seen; only meaningful while done=1
//   err_count  saturating mismatch count
//   fail_addr  address of the first mismatch of the run
module mem_bist_seq #(
    parameter int DEPTH   = 32,
    parameter int AW      = 5,
    parameter int DW      = 8,
    parameter int RD_WAIT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] seed,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data_in,
    output logic          write,
    output logic          read,
    input  logic [DW-1:0] data_out,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW:0]   err_count,
    output logic [AW-1:0] fail_addr
);

    localparam int WW = (RD_WAIT > 0) ? $clog2(RD_WAIT + 1) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(RD_WAIT);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] addr_nxt, fail_addr_nxt;
    logic [DW-1:0] data_in_nxt, seed_q, seed_nxt;
    logic          write_nxt, read_nxt, busy_nxt, done_nxt, pass_nxt;
    logic [AW:0]   err_count_nxt;
    logic [WW-1:0] wait_cnt, wait_cnt_nxt;

    // Saturating increment so a badly broken memory cannot wrap the count to zero.
    function automatic logic [AW:0] sat_inc(input logic [AW:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Expected word at an address: seed plus zero-extended address, modulo 2^DW.
    function automatic logic [DW-1:0] exp_pat(input logic [DW-1:0] s, input logic [AW-1:0] a);
        return s + DW'(a);
    endfunction

    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr;
        data_in_nxt   = data_in;
        write_nxt     = write;
        read_nxt      = read;
        busy_nxt      = busy;
        done_nxt      = done;
        pass_nxt      = pass;
        err_count_nxt = err_count;
        fail_addr_nxt = fail_addr;
        seed_nxt      = seed_q;
        wait_cnt_nxt  = wait_cnt;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt     = WRITE;
                    seed_nxt      = seed;
                    addr_nxt      = '0;
                    data_in_nxt   = exp_pat(seed, '0);
                    write_nxt     = 1'b1;
                    read_nxt      = 1'b0;
                    busy_nxt      = 1'b1;
                    done_nxt      = 1'b0;
                    pass_nxt      = 1'b0;
                    err_count_nxt = '0;
                    fail_addr_nxt = '0;
                    wait_cnt_nxt  = '0;
                end
            end
            WRITE: begin
                if (addr == LAST_ADDR) begin
                    state_nxt    = READ;
                    addr_nxt     = '0;
                    write_nxt    = 1'b0;
                    read_nxt     = 1'b1;
                    wait_cnt_nxt = '0;
                end else begin
                    addr_nxt    = addr + 1'b1;
                    data_in_nxt = exp_pat(seed_q, addr + 1'b1);
                end
            end
            READ: begin
                if (wait_cnt == WAIT_LAST) begin
                    // Last edge of this address's read window: compare now.
                    if (data_out != exp_pat(seed_q, addr)) begin
                        err_count_nxt = sat_inc(err_count);
                        if (err_count == '0)
                            fail_addr_nxt = addr;
                    end
                    wait_cnt_nxt = '0;
                    if (addr == LAST_ADDR) begin
                        state_nxt = DONE;
                        read_nxt  = 1'b0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        pass_nxt  = (err_count_nxt == '0);
                    end else begin
                        addr_nxt = addr + 1'b1;
                    end
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr      <= '0;
            data_in   <= '0;
            write     <= 1'b0;
            read      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            seed_q    <= '0;
            wait_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            addr      <= addr_nxt;
            data_in   <= data_in_nxt;
            write     <= write_nxt;
            read      <= read_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            pass      <= pass_nxt;
            err_count <= err_count_nxt;
            fail_addr <= fail_addr_nxt;
            seed_q    <= seed_nxt;
            wait_cnt  <= wait_cnt_nxt;
        end
    end

endmodule
